instr_fetch_unit: RTL and testbench

Instruction fetch front end that produces the PC/instruction pairs consumed by the IF/ID pipeline register. Issues word requests to instruction memory over a req/gnt/rvalid handshake, buffers in-order responses in a small FIFO, honours the decode-side stall, and redirects on taken branches/jumps resolved in Execute. Its outputs `Addr`/`Inst` feed the IF/ID register inputs of the same names; `InstValid` qualifies them.

---
 rtl/instr_fetch_unit_if.sv | 29 ++
 rtl/instr_fetch_unit.sv | 147 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// Instruction memory request/response bundle.
//   imem_req    fetch unit -> memory   request valid
//   imem_addr   fetch unit -> memory   word-aligned request address
//   imem_gnt    memory -> fetch unit   request accepted this cycle
//   imem_rvalid memory -> fetch unit   in-order response data valid
//   imem_rdata  memory -> fetch unit   response instruction word
interface instr_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end feeding the IF/ID register.
// Issues word requests over a req/gnt/rvalid handshake, keeps the returned
// instructions in a small in-order buffer tagged with their PCs, holds the
// head while decode stalls and flushes/redirects on an Execute redirect.
//   clk, rst      clock, synchronous active-high reset
//   StallF        consumer not accepting; head entry held
//   PCSrcE        one-cycle redirect pulse
//   PCTargetE     redirect target (low two bits ignored)
//   imem          instruction memory port (master side)
//   Addr/Inst     head entry PC and instruction (NOP when empty)
//   InstValid     head entry present
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               StallF,
    input  logic               PCSrcE,
    input  logic [31:0]        PCTargetE,
    instr_fetch_unit_if.master imem,
    output logic [31:0]        Addr,
    output logic [31:0]        Inst,
    output logic               InstValid
);
    localparam int unsigned   PW       = $clog2(DEPTH);
    localparam int unsigned   CW       = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1'b1);
    localparam logic [31:0]   NOP_INST = 32'h0000_0013;

    logic [31:0]   pc_r;
    logic [31:0]   last_addr_r;
    logic [31:0]   buf_addr_r [DEPTH];
    logic [31:0]   buf_inst_r [DEPTH];
    logic [31:0]   tag_r      [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] tag_wr_ptr_r;
    logic [PW-1:0] tag_rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] pending_r;
    logic [CW-1:0] discard_r;

    logic [CW:0]   inflight_s;
    logic          credit_ok_s;
    logic          req_s;
    logic          issue_s;
    logic          empty_s;
    logic          pop_s;
    logic          rsp_drop_s;
    logic          rsp_keep_s;
    logic [CW-1:0] flush_sum_s;
    logic [CW-1:0] discard_flush_s;

    // Fetch is word-aligned, so the target's byte offset is dropped.
    logic unused_tgt_s;
    assign unused_tgt_s = ^PCTargetE[1:0];

    // Request credit and the handshake events of this cycle.
    always_comb begin
        inflight_s  = {1'b0, pending_r} + {1'b0, count_r};
        credit_ok_s = (inflight_s < {1'b0, DEPTH_C});
        req_s       = !rst && !PCSrcE && credit_ok_s;
        issue_s     = req_s && imem.imem_gnt;
        empty_s     = (count_r == {CW{1'b0}});
        pop_s       = !rst && !empty_s && !StallF;
        rsp_drop_s  = !rst && imem.imem_rvalid && (discard_r != {CW{1'b0}});
        // A response with nothing pending is stray and never enters the buffer.
        rsp_keep_s  = !rst && !PCSrcE && imem.imem_rvalid &&
                      (discard_r == {CW{1'b0}}) && (pending_r != {CW{1'b0}});
        // On redirect every outstanding request becomes a discard, minus the
        // one returning right now (which is dropped in the same cycle).
        flush_sum_s = discard_r + pending_r;
        if (imem.imem_rvalid && (flush_sum_s != {CW{1'b0}})) begin
            discard_flush_s = flush_sum_s - CNT_ONE;
        end else begin
            discard_flush_s = flush_sum_s;
        end
    end

    assign imem.imem_req  = req_s;
    assign imem.imem_addr = pc_r;

    // Head entry straight from storage; when empty, Addr keeps the last consumed PC.
    assign InstValid = !empty_s;
    assign Addr      = empty_s ? last_addr_r : buf_addr_r[rd_ptr_r];
    assign Inst      = empty_s ? NOP_INST    : buf_inst_r[rd_ptr_r];

    // Fetch PC, occupancy/credit counters and buffer pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r         <= RESET_PC;
            last_addr_r  <= 32'h0000_0000;
            wr_ptr_r     <= {PW{1'b0}};
            rd_ptr_r     <= {PW{1'b0}};
            tag_wr_ptr_r <= {PW{1'b0}};
            tag_rd_ptr_r <= {PW{1'b0}};
            count_r      <= {CW{1'b0}};
            pending_r    <= {CW{1'b0}};
            discard_r    <= {CW{1'b0}};
        end else if (PCSrcE) begin
            pc_r         <= {PCTargetE[31:2], 2'b00};
            wr_ptr_r     <= {PW{1'b0}};
            rd_ptr_r     <= {PW{1'b0}};
            tag_wr_ptr_r <= {PW{1'b0}};
            tag_rd_ptr_r <= {PW{1'b0}};
            count_r      <= {CW{1'b0}};
            pending_r    <= {CW{1'b0}};
            discard_r    <= discard_flush_s;
            if (pop_s) begin
                last_addr_r <= buf_addr_r[rd_ptr_r];
            end
        end else begin
            if (issue_s) begin
                pc_r         <= pc_r + 32'd4;
                tag_wr_ptr_r <= tag_wr_ptr_r + PTR_ONE;
            end
            if (rsp_keep_s) begin
                wr_ptr_r     <= wr_ptr_r + PTR_ONE;
                tag_rd_ptr_r <= tag_rd_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r    <= rd_ptr_r + PTR_ONE;
                last_addr_r <= buf_addr_r[rd_ptr_r];
            end
            if (rsp_drop_s) begin
                discard_r <= discard_r - CNT_ONE;
            end
            pending_r <= pending_r + CW'(issue_s) - CW'(rsp_keep_s);
            count_r   <= count_r + CW'(rsp_keep_s) - CW'(pop_s);
        end
    end

    // Tag and response storage; validity is carried by the counters, and the
    // credit rule guarantees neither write lands on an unread entry.
    always_ff @(posedge clk) begin
        if (issue_s) begin
            tag_r[tag_wr_ptr_r] <= pc_r;
        end
        if (rsp_keep_s) begin
            buf_addr_r[wr_ptr_r] <= tag_r[tag_rd_ptr_r];
            buf_inst_r[wr_ptr_r] <= imem.imem_rdata;
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'hFFFF_FFFC;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;
    localparam logic [31:0] KEY      = 32'h5A5A_0000;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        StallF    = 1'b0;
    logic        PCSrcE    = 1'b0;
    logic [31:0] PCTargetE = 32'h0000_0000;
    logic [31:0] Addr;
    logic [31:0] Inst;
    logic        InstValid;

    int n_checks = 0;
    int n_errors = 0;

    instr_fetch_unit_if mif ();

    instr_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .StallF    (StallF),
        .PCSrcE    (PCSrcE),
        .PCTargetE (PCTargetE),
        .imem      (mif.master),
        .Addr      (Addr),
        .Inst      (Inst),
        .InstValid (InstValid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory model: grant after gnt_delay waiting cycles, in-order data rv_lat cycles later.
    int          cyc       = 0;
    int          wait_cnt  = 0;
    int          gnt_delay = 0;
    int          rv_lat    = 1;
    logic [31:0] q_addr[$];
    int          q_due[$];

    assign mif.imem_gnt = mif.imem_req && (wait_cnt >= gnt_delay);

    always @(posedge clk) begin
        if (rst) begin
            q_addr.delete();
            q_due.delete();
            wait_cnt <= 0;
        end else if (mif.imem_req && mif.imem_gnt) begin
            q_addr.push_back(mif.imem_addr);
            q_due.push_back(cyc + rv_lat);
            wait_cnt <= 0;
        end else if (mif.imem_req) begin
            wait_cnt <= wait_cnt + 1;
        end else begin
            wait_cnt <= 0;
        end
        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (!rst && q_due.size() > 0 && q_due[0] <= cyc) begin
            mif.imem_rvalid = 1'b1;
            mif.imem_rdata  = q_addr[0] ^ KEY;
            void'(q_addr.pop_front());
            void'(q_due.pop_front());
        end else begin
            mif.imem_rvalid = 1'b0;
            mif.imem_rdata  = 32'h0000_0000;
        end
    end

    // Stream monitor: expected next head PC and next request PC.
    logic [31:0] exp_addr = RESET_PC;
    logic [31:0] exp_req  = RESET_PC;

    always @(negedge clk) begin
        #2;
        if (rst) begin
            exp_addr = RESET_PC;
            exp_req  = RESET_PC;
        end else begin
            if (InstValid) begin
                check("mon_addr", Addr, exp_addr);
                check("mon_inst", Inst, exp_addr ^ KEY);
            end else begin
                check("mon_nop", Inst, NOP_INST);
            end
            if (mif.imem_req) begin
                check("mon_req_addr", mif.imem_addr, exp_req);
            end
            if (PCSrcE) begin
                exp_addr = {PCTargetE[31:2], 2'b00};
                exp_req  = {PCTargetE[31:2], 2'b00};
            end else begin
                if (mif.imem_req && mif.imem_gnt) exp_req = exp_req + 32'd4;
                if (InstValid && !StallF)         exp_addr = exp_addr + 32'd4;
            end
        end
    end

    logic stall_req_exp [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    int   n_valid;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_req",   mif.imem_req, 1'b0);
        check("rst_addr",  Addr, 32'h0000_0000);
        check("rst_inst",  Inst, NOP_INST);
        check("rst_valid", InstValid, 1'b0);
        rst = 1'b0;
        #1;
        check("first_req",  mif.imem_req, 1'b1);
        check("first_addr", mif.imem_addr, RESET_PC);
        @(negedge clk); #1;
        check("lat_c2_valid", InstValid, 1'b0);
        @(negedge clk); #1;
        check("lat_c3_valid", InstValid, 1'b1);
        check("lat_c3_addr",  Addr, RESET_PC);
        check("lat_c3_inst",  Inst, RESET_PC ^ KEY);
        @(negedge clk); #1;
        check("wrap_addr", Addr, 32'h0000_0000);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            check("run_valid", InstValid, 1'b1);
        end

        // Stall for 5 cycles from the pending=1/count=1 steady state
        @(negedge clk);
        StallF = 1'b1;
        #1;
        check("stall_req", mif.imem_req, stall_req_exp[0]);
        for (int i = 1; i < 5; i++) begin
            @(negedge clk); #1;
            check("stall_req", mif.imem_req, stall_req_exp[i]);
            check("stall_valid", InstValid, 1'b1);
        end
        @(negedge clk);
        StallF = 1'b0;
        #1;
        check("unstall_req0", mif.imem_req, 1'b0);
        @(negedge clk); #1;
        check("unstall_req1", mif.imem_req, 1'b1);

        // Redirect while stalled with a full buffer
        repeat (3) @(negedge clk);
        StallF = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        check("full_req",   mif.imem_req, 1'b0);
        check("full_valid", InstValid, 1'b1);
        PCSrcE    = 1'b1;
        PCTargetE = 32'h0000_0200;
        #1;
        check("rs_pulse_req", mif.imem_req, 1'b0);
        @(negedge clk);
        PCSrcE = 1'b0;
        #1;
        check("rs_valid1", InstValid, 1'b0);
        check("rs_req",    mif.imem_req, 1'b1);
        check("rs_addr",   mif.imem_addr, 32'h0000_0200);
        @(negedge clk); #1;
        check("rs_valid2", InstValid, 1'b0);
        @(negedge clk); #1;
        check("rs_valid3", InstValid, 1'b1);
        check("rs_head",   Addr, 32'h0000_0200);
        StallF = 1'b0;

        // Redirect with responses outstanding (3-cycle memory latency)
        rv_lat = 3;
        repeat (6) @(negedge clk);
        #1;
        PCSrcE    = 1'b1;
        PCTargetE = 32'h0000_0103;
        #1;
        check("rd_pulse_req", mif.imem_req, 1'b0);
        @(negedge clk);
        PCSrcE = 1'b0;
        #1;
        check("rd_req",    mif.imem_req, 1'b1);
        check("rd_addr",   mif.imem_addr, 32'h0000_0100);
        check("rd_valid1", InstValid, 1'b0);
        for (int i = 2; i < 5; i++) begin
            @(negedge clk); #1;
            check("rd_bubble", InstValid, 1'b0);
        end
        @(negedge clk); #1;
        check("rd_valid5", InstValid, 1'b1);
        check("rd_head",   Addr, 32'h0000_0100);

        // Slow memory: grant after 3 waiting cycles, data 2 cycles later
        gnt_delay = 3;
        rv_lat    = 2;
        n_valid   = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (InstValid) n_valid++;
        end
        check("slow_count_ok", (n_valid >= 8 && n_valid <= 14), 1'b1);

        // Reset mid-stream with responses in flight
        gnt_delay = 0;
        repeat (5) @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("mrst_req", mif.imem_req, 1'b0);
        @(negedge clk); #1;
        check("mrst_addr",  Addr, 32'h0000_0000);
        check("mrst_inst",  Inst, NOP_INST);
        check("mrst_valid", InstValid, 1'b0);
        check("mrst_req2",  mif.imem_req, 1'b0);
        rst = 1'b0;
        #1;
        check("mrst_first_req",  mif.imem_req, 1'b1);
        check("mrst_first_addr", mif.imem_addr, RESET_PC);
        @(negedge clk); #1;
        check("mrst_c2_valid", InstValid, 1'b0);
        @(negedge clk); #1;
        check("mrst_c3_valid", InstValid, 1'b0);
        @(negedge clk); #1;
        check("mrst_c4_valid", InstValid, 1'b1);
        check("mrst_c4_addr",  Addr, RESET_PC);
        @(negedge clk); #1;
        check("mrst_wrap_addr", Addr, 32'h0000_0000);
        check("mrst_wrap_inst", Inst, KEY);

        repeat (8) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
